// File: rtl/bus_write_arbiter_mux_if.sv
// AXI3 write-channel bundle (AW, W, B) shared by the downstream write port
// and each upstream write master. "master" is the side that issues writes,
// "slave" is the side that accepts them.
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both 1; the sender holds the payload stable
// while valid=1 and ready=0.
interface bus_write_arbiter_mux_if #(
   parameter int ID_W   = 4,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]     awid;
   logic [31:0]         awaddr;
   logic [3:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic [1:0]          awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [ID_W-1:0]     wid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/bus_write_arbiter_mux.sv
// Two-master AXI3 write arbiter. Owns one whole write transaction at a time
// (AW, then the W burst, then B) with round-robin grant on ties. Downstream
// wlast comes from a beat counter; the master's wlast is only monitored and
// a disagreement raises a one-cycle wlast_err pulse.
// dbg_state encoding: 0=IDLE, 1=ADDR, 2=DATA, 3=RESP.
module bus_write_arbiter_mux #(
   parameter int ID_W   = 4,
   parameter int DATA_W = 32
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   bus_write_arbiter_mux_if.master  dn,
   bus_write_arbiter_mux_if.slave   m0,
   bus_write_arbiter_mux_if.slave   m1,
   output logic                     m0_grnt,
   output logic                     m1_grnt,
   output logic                     wlast_err,
   output logic [1:0]               dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

   state_t state_q, state_d;
   logic   gsel_q, gsel_d;     // granted master: 0 = m0, 1 = m1
   logic   last_q, last_d;     // master granted most recently
   logic [3:0] cnt_q, len_q;
   logic   err_q;

   // Signals of whichever master currently holds the grant
   logic [ID_W-1:0]     sel_awid, sel_wid;
   logic [31:0]         sel_awaddr;
   logic [3:0]          sel_awlen, sel_awcache;
   logic [2:0]          sel_awsize, sel_awprot;
   logic [1:0]          sel_awburst, sel_awlock;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DATA_W/8-1:0] sel_wstrb;
   logic sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
   logic aw_hs, w_hs, b_hs, cnt_last;

   assign sel_awid    = gsel_q ? m1.awid    : m0.awid;
   assign sel_awaddr  = gsel_q ? m1.awaddr  : m0.awaddr;
   assign sel_awlen   = gsel_q ? m1.awlen   : m0.awlen;
   assign sel_awsize  = gsel_q ? m1.awsize  : m0.awsize;
   assign sel_awburst = gsel_q ? m1.awburst : m0.awburst;
   assign sel_awlock  = gsel_q ? m1.awlock  : m0.awlock;
   assign sel_awcache = gsel_q ? m1.awcache : m0.awcache;
   assign sel_awprot  = gsel_q ? m1.awprot  : m0.awprot;
   assign sel_awvalid = gsel_q ? m1.awvalid : m0.awvalid;
   assign sel_wid     = gsel_q ? m1.wid     : m0.wid;
   assign sel_wdata   = gsel_q ? m1.wdata   : m0.wdata;
   assign sel_wstrb   = gsel_q ? m1.wstrb   : m0.wstrb;
   assign sel_wlast   = gsel_q ? m1.wlast   : m0.wlast;
   assign sel_wvalid  = gsel_q ? m1.wvalid  : m0.wvalid;
   assign sel_bready  = gsel_q ? m1.bready  : m0.bready;

   assign cnt_last = (cnt_q == len_q);
   assign aw_hs    = (state_q == ADDR) && sel_awvalid && dn.awready;
   assign w_hs     = (state_q == DATA) && sel_wvalid && dn.wready;
   assign b_hs     = (state_q == RESP) && dn.bvalid && sel_bready;

   assign m0_grnt   = (state_q != IDLE) && !gsel_q;
   assign m1_grnt   = (state_q != IDLE) &&  gsel_q;
   assign wlast_err = err_q;
   assign dbg_state = state_q;

   // State, grant, beat counter and wlast monitor registers
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= IDLE;
         gsel_q  <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 4'd0;
         len_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gsel_q  <= gsel_d;
         last_q  <= last_d;
         if (aw_hs) begin
            len_q <= sel_awlen;
            cnt_q <= 4'd0;
         end else if (w_hs) begin
            cnt_q <= cnt_q + 4'd1;
         end
         err_q <= w_hs && (sel_wlast != cnt_last);
      end
   end

   // Next-state and round-robin arbitration
   always_comb begin
      state_d = state_q;
      gsel_d  = gsel_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0.awvalid || m1.awvalid) begin
               gsel_d  = (m0.awvalid && m1.awvalid) ? ~last_q : m1.awvalid;
               last_d  = gsel_d;
               state_d = ADDR;
            end
         end
         ADDR:    if (aw_hs) state_d = DATA;
         DATA:    if (w_hs && cnt_last) state_d = RESP;
         RESP:    if (b_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Channel routing: only the channel owned by the current state is live
   always_comb begin
      dn.awid = '0; dn.awaddr = '0; dn.awlen = '0; dn.awsize = '0;
      dn.awburst = '0; dn.awlock = '0; dn.awcache = '0; dn.awprot = '0;
      dn.awvalid = 1'b0;
      dn.wid = '0; dn.wdata = '0; dn.wstrb = '0; dn.wlast = 1'b0; dn.wvalid = 1'b0;
      dn.bready = 1'b0;
      m0.awready = 1'b0; m0.wready = 1'b0; m0.bid = '0; m0.bresp = '0; m0.bvalid = 1'b0;
      m1.awready = 1'b0; m1.wready = 1'b0; m1.bid = '0; m1.bresp = '0; m1.bvalid = 1'b0;
      case (state_q)
         ADDR: begin
            dn.awid    = sel_awid;
            dn.awaddr  = sel_awaddr;
            dn.awlen   = sel_awlen;
            dn.awsize  = sel_awsize;
            dn.awburst = sel_awburst;
            dn.awlock  = sel_awlock;
            dn.awcache = sel_awcache;
            dn.awprot  = sel_awprot;
            dn.awvalid = sel_awvalid;
            m0.awready = !gsel_q && dn.awready;
            m1.awready =  gsel_q && dn.awready;
         end
         DATA: begin
            dn.wid     = sel_wid;
            dn.wdata   = sel_wdata;
            dn.wstrb   = sel_wstrb;
            dn.wlast   = cnt_last;
            dn.wvalid  = sel_wvalid;
            m0.wready  = !gsel_q && dn.wready;
            m1.wready  =  gsel_q && dn.wready;
         end
         RESP: begin
            dn.bready = sel_bready;
            if (gsel_q) begin
               m1.bid = dn.bid; m1.bresp = dn.bresp; m1.bvalid = dn.bvalid;
            end else begin
               m0.bid = dn.bid; m0.bresp = dn.bresp; m0.bvalid = dn.bvalid;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_write_arbiter_mux.sv
// Directed bench for bus_write_arbiter_mux: a table of write transactions
// replayed through one driver task, plus a hand-written mid-burst reset.
module tb_bus_write_arbiter_mux;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   bus_write_arbiter_mux_if #(.ID_W(4), .DATA_W(32)) dn_if ();
   bus_write_arbiter_mux_if #(.ID_W(4), .DATA_W(32)) m0_if ();
   bus_write_arbiter_mux_if #(.ID_W(4), .DATA_W(32)) m1_if ();

   logic       m0_grnt, m1_grnt, wlast_err;
   logic [1:0] dbg_state;

   bus_write_arbiter_mux #(.ID_W(4), .DATA_W(32)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .dn        (dn_if),
      .m0        (m0_if),
      .m1        (m1_if),
      .m0_grnt   (m0_grnt),
      .m1_grnt   (m1_grnt),
      .wlast_err (wlast_err),
      .dbg_state (dbg_state)
   );

   // Downstream slave side
   logic       dn_awready, dn_wready, dn_bvalid;
   logic [3:0] dn_bid;
   logic [1:0] dn_bresp;
   assign dn_if.awready = dn_awready;
   assign dn_if.wready  = dn_wready;
   assign dn_if.bvalid  = dn_bvalid;
   assign dn_if.bid     = dn_bid;
   assign dn_if.bresp   = dn_bresp;

   // Upstream masters, indexed by master number
   logic [1:0] m_awvalid, m_wvalid, m_wlast, m_bready;
   logic [3:0] m_awid [2], m_awlen [2], m_awcache [2], m_wid [2], m_wstrb [2];
   logic [31:0] m_awaddr [2], m_wdata [2];
   logic [2:0] m_awsize [2], m_awprot [2];
   logic [1:0] m_awburst [2], m_awlock [2];

   assign m0_if.awvalid = m_awvalid[0]; assign m1_if.awvalid = m_awvalid[1];
   assign m0_if.awid    = m_awid[0];    assign m1_if.awid    = m_awid[1];
   assign m0_if.awaddr  = m_awaddr[0];  assign m1_if.awaddr  = m_awaddr[1];
   assign m0_if.awlen   = m_awlen[0];   assign m1_if.awlen   = m_awlen[1];
   assign m0_if.awsize  = m_awsize[0];  assign m1_if.awsize  = m_awsize[1];
   assign m0_if.awburst = m_awburst[0]; assign m1_if.awburst = m_awburst[1];
   assign m0_if.awlock  = m_awlock[0];  assign m1_if.awlock  = m_awlock[1];
   assign m0_if.awcache = m_awcache[0]; assign m1_if.awcache = m_awcache[1];
   assign m0_if.awprot  = m_awprot[0];  assign m1_if.awprot  = m_awprot[1];
   assign m0_if.wid     = m_wid[0];     assign m1_if.wid     = m_wid[1];
   assign m0_if.wdata   = m_wdata[0];   assign m1_if.wdata   = m_wdata[1];
   assign m0_if.wstrb   = m_wstrb[0];   assign m1_if.wstrb   = m_wstrb[1];
   assign m0_if.wlast   = m_wlast[0];   assign m1_if.wlast   = m_wlast[1];
   assign m0_if.wvalid  = m_wvalid[0];  assign m1_if.wvalid  = m_wvalid[1];
   assign m0_if.bready  = m_bready[0];  assign m1_if.bready  = m_bready[1];

   logic [1:0] m_awready_o, m_wready_o, m_bvalid_o;
   logic [3:0] m_bid_o [2];
   logic [1:0] m_bresp_o [2];
   assign m_awready_o = {m1_if.awready, m0_if.awready};
   assign m_wready_o  = {m1_if.wready,  m0_if.wready};
   assign m_bvalid_o  = {m1_if.bvalid,  m0_if.bvalid};
   assign m_bid_o[0]  = m0_if.bid;   assign m_bid_o[1]  = m1_if.bid;
   assign m_bresp_o[0] = m0_if.bresp; assign m_bresp_o[1] = m1_if.bresp;

   // Scoreboard counters
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   typedef struct packed {
      int          m;          // master issuing the write
      int          len;        // awlen
      logic [31:0] addr;
      logic [31:0] base;       // beat k carries base+k
      bit          wtog;       // downstream wready toggles 1,0,1,0...
      int          bhold;      // cycles bvalid waits with master bready=0
      logic [1:0]  bresp;
      int          errbeat;    // beat index where master raises an early wlast, -1 none
      bit          other_req;  // other master requests at the same time
      int          exp_err;    // expected number of wlast_err pulses
   } txn_t;

   txn_t vec [9];

   // Drives one full write for master t.m, acting as both that master and the
   // downstream slave, and checks every channel cycle by cycle.
   task automatic txn(input txn_t t);
      int m = t.m;
      int o = 1 - t.m;
      logic [3:0] id = 4'(t.m + 3);
      logic [1:0] g = (t.m == 1) ? 2'b10 : 2'b01;
      int b = 0;
      int cyc = 0;
      int errs = 0;
      logic wr, mlast, exp_e;
      m_awvalid[m] = 1'b1; m_awid[m] = id; m_awaddr[m] = t.addr;
      m_awlen[m] = 4'(t.len); m_awsize[m] = 3'd2; m_awburst[m] = 2'b01;
      m_awlock[m] = 2'b00; m_awcache[m] = 4'h3; m_awprot[m] = 3'h2;
      m_wvalid[m] = 1'b1; m_wid[m] = id; m_wdata[m] = t.base; m_wstrb[m] = 4'hF;
      m_wlast[m] = 1'b0; m_bready[m] = 1'b0;
      if (t.other_req) begin
         m_awvalid[o] = 1'b1; m_awaddr[o] = t.addr + 32'h40; m_awlen[o] = 4'd0;
      end
      dn_awready = 1'b1; dn_wready = 1'b0; dn_bvalid = 1'b0;
      #1;
      chk("idle_awvalid", 64'(dn_if.awvalid), 64'd0);
      chk("idle_grant", 64'({m1_grnt, m0_grnt}), 64'd0);
      chk("early_wready", 64'(m_wready_o[m]), 64'd0);
      step();
      chk("addr_state", 64'(dbg_state), 64'd1);
      chk("addr_grant", 64'({m1_grnt, m0_grnt}), 64'(g));
      chk("addr_awvalid", 64'(dn_if.awvalid), 64'd1);
      chk("addr_awaddr", 64'(dn_if.awaddr), 64'(t.addr));
      chk("addr_awlen", 64'(dn_if.awlen), 64'(t.len));
      chk("addr_awid", 64'(dn_if.awid), 64'(id));
      chk("addr_awready_own", 64'(m_awready_o[m]), 64'd1);
      chk("addr_awready_other", 64'(m_awready_o[o]), 64'd0);
      chk("addr_wvalid", 64'(dn_if.wvalid), 64'd0);
      chk("addr_wready", 64'(m_wready_o[m]), 64'd0);
      step();
      m_awvalid[m] = 1'b0;
      while (b <= t.len && cyc < 64) begin
         wr = t.wtog ? (cyc % 2 == 0) : 1'b1;
         mlast = (b == t.len) || (b == t.errbeat);
         dn_wready = wr; m_wdata[m] = t.base + 32'(b); m_wlast[m] = mlast;
         dn_bvalid = 1'b1;
         #1;
         chk("data_state", 64'(dbg_state), 64'd2);
         chk("data_wvalid", 64'(dn_if.wvalid), 64'd1);
         chk("data_wdata", 64'(dn_if.wdata), 64'(t.base + 32'(b)));
         chk("data_wid", 64'(dn_if.wid), 64'(id));
         chk("data_wlast", 64'(dn_if.wlast), 64'(b == t.len));
         chk("data_wready_own", 64'(m_wready_o[m]), 64'(wr));
         chk("data_wready_other", 64'(m_wready_o[o]), 64'd0);
         chk("data_awvalid", 64'(dn_if.awvalid), 64'd0);
         chk("data_bready", 64'(dn_if.bready), 64'd0);
         chk("data_bvalid_fwd", 64'(m_bvalid_o[m]), 64'd0);
         exp_e = wr && (mlast != (b == t.len));
         @(posedge aclk);
         #1;
         chk("wlast_err", 64'(wlast_err), 64'(exp_e));
         errs += int'(wlast_err);
         if (wr) b++;
         cyc++;
      end
      m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; dn_wready = 1'b0;
      dn_bvalid = 1'b1; dn_bid = id; dn_bresp = t.bresp;
      for (int h = 0; h < t.bhold; h++) begin
         #1;
         chk("resp_state", 64'(dbg_state), 64'd3);
         chk("resp_bready_hold", 64'(dn_if.bready), 64'd0);
         chk("resp_bvalid_own", 64'(m_bvalid_o[m]), 64'd1);
         chk("resp_bvalid_other", 64'(m_bvalid_o[o]), 64'd0);
         @(posedge aclk);
         #1;
      end
      m_bready[m] = 1'b1;
      #1;
      chk("resp_state", 64'(dbg_state), 64'd3);
      chk("resp_bready", 64'(dn_if.bready), 64'd1);
      chk("resp_bid", 64'(m_bid_o[m]), 64'(id));
      chk("resp_bresp", 64'(m_bresp_o[m]), 64'(t.bresp));
      chk("resp_grant", 64'({m1_grnt, m0_grnt}), 64'(g));
      step();
      dn_bvalid = 1'b0; m_bready[m] = 1'b0;
      chk("back_idle", 64'(dbg_state), 64'd0);
      chk("back_idle_grant", 64'({m1_grnt, m0_grnt}), 64'd0);
      chk("err_pulses", 64'(errs), 64'(t.exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Tie from reset -> m0, then strict alternation, then the directed cases
      vec[0] = '{m:0, len:0,  addr:32'h0000_0100, base:32'h0000_0011, wtog:0, bhold:0, bresp:2'b00, errbeat:-1, other_req:1, exp_err:0};
      vec[1] = '{m:1, len:0,  addr:32'h0000_0200, base:32'h0000_0022, wtog:0, bhold:0, bresp:2'b00, errbeat:-1, other_req:1, exp_err:0};
      vec[2] = '{m:0, len:1,  addr:32'h0000_0300, base:32'h0000_0033, wtog:0, bhold:0, bresp:2'b00, errbeat:-1, other_req:1, exp_err:0};
      vec[3] = '{m:1, len:0,  addr:32'h0000_0400, base:32'h0000_0044, wtog:0, bhold:0, bresp:2'b00, errbeat:-1, other_req:0, exp_err:0};
      vec[4] = '{m:0, len:0,  addr:32'h1FC0_0000, base:32'hDEAD_BEEF, wtog:0, bhold:0, bresp:2'b00, errbeat:-1, other_req:0, exp_err:0};
      vec[5] = '{m:1, len:3,  addr:32'h0000_1000, base:32'hCAFE_0000, wtog:1, bhold:0, bresp:2'b00, errbeat:-1, other_req:0, exp_err:0};
      vec[6] = '{m:0, len:15, addr:32'h0000_2000, base:32'h5A5A_0000, wtog:0, bhold:0, bresp:2'b00, errbeat:7,  other_req:0, exp_err:1};
      vec[7] = '{m:0, len:2,  addr:32'h0000_3000, base:32'h1234_0000, wtog:0, bhold:3, bresp:2'b10, errbeat:-1, other_req:0, exp_err:0};
      vec[8] = '{m:1, len:15, addr:32'h0000_4000, base:32'h7700_0000, wtog:1, bhold:1, bresp:2'b01, errbeat:-1, other_req:0, exp_err:0};

      aresetn = 1'b0;
      dn_awready = 1'b0; dn_wready = 1'b0; dn_bvalid = 1'b0; dn_bid = '0; dn_bresp = '0;
      m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
      for (int i = 0; i < 2; i++) begin
         m_awid[i] = '0; m_awaddr[i] = '0; m_awlen[i] = '0; m_awsize[i] = '0;
         m_awburst[i] = '0; m_awlock[i] = '0; m_awcache[i] = '0; m_awprot[i] = '0;
         m_wid[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0;
      end
      step();
      step();
      chk("rst_state", 64'(dbg_state), 64'd0);
      chk("rst_grant", 64'({m1_grnt, m0_grnt}), 64'd0);
      chk("rst_awvalid", 64'(dn_if.awvalid), 64'd0);
      chk("rst_wvalid", 64'(dn_if.wvalid), 64'd0);
      chk("rst_bready", 64'(dn_if.bready), 64'd0);
      chk("rst_awaddr", 64'(dn_if.awaddr), 64'd0);
      chk("rst_m_readys", 64'({m_awready_o, m_wready_o, m_bvalid_o}), 64'd0);
      chk("rst_wlast_err", 64'(wlast_err), 64'd0);
      aresetn = 1'b1;

      for (int i = 0; i < 9; i++) txn(vec[i]);

      // Reset during beat 2 of a 4-beat m0 burst
      m_awvalid[0] = 1'b1; m_awid[0] = 4'h3; m_awaddr[0] = 32'h0000_5000; m_awlen[0] = 4'd3;
      m_wvalid[0] = 1'b1; m_wdata[0] = 32'hABCD_0000; m_wlast[0] = 1'b0;
      dn_awready = 1'b1; dn_wready = 1'b1;
      step();
      step();
      m_awvalid[0] = 1'b0;
      chk("mid_data_state", 64'(dbg_state), 64'd2);
      step();
      m_wdata[0] = 32'hABCD_0001;
      aresetn = 1'b0;
      step();
      chk("mid_rst_state", 64'(dbg_state), 64'd0);
      chk("mid_rst_grant", 64'({m1_grnt, m0_grnt}), 64'd0);
      chk("mid_rst_wvalid", 64'(dn_if.wvalid), 64'd0);
      chk("mid_rst_wready", 64'(m_wready_o), 64'd0);
      chk("mid_rst_awvalid", 64'(dn_if.awvalid), 64'd0);
      aresetn = 1'b1;
      m_wvalid[0] = 1'b0;
      txn('{m:1, len:1, addr:32'h0000_6000, base:32'h6600_0000, wtog:0, bhold:0, bresp:2'b00, errbeat:-1, other_req:0, exp_err:0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bus_write_arbiter_mux.md
Name: bus_write_arbiter_mux

Overview:
Write-side counterpart of the read-channel master multiplexer. It arbitrates two AXI3 write masters (instruction-side/data-side cache and uncached write path) onto the single write port of the bus. It owns one complete write transaction at a time (AW, then W burst, then B) under a state machine with round-robin grant and a beat counter. It sits between the per-master write ports and the AXI interconnect/bridge.

Parameters:
ID_W, 4, width of awid/wid/bid
DATA_W, 32, width of wdata; wstrb is DATA_W/8

Ports:
aclk  input  1  clock, all logic on rising edge
aresetn  input  1  synchronous active-low reset
awid,awaddr,awlen,awsize,awburst,awlock,awcache,awprot  output  ID_W,32,4,3,2,2,4,3  downstream AW payload
awvalid  output  1  downstream AW valid
awready  input  1  downstream AW ready
wid,wdata,wstrb  output  ID_W,DATA_W,DATA_W/8  downstream W payload
wlast  output  1  downstream last beat, generated from beat counter
wvalid  output  1  downstream W valid
wready  input  1  downstream W ready
bid,bresp  input  ID_W,2  downstream B payload
bvalid  input  1  downstream B valid
bready  output  1  downstream B ready
mN_aw* (N=0,1)  input  as downstream  master N AW payload and mN_awvalid
mN_awready  output  1  master N AW ready
mN_wid,mN_wdata,mN_wstrb,mN_wlast,mN_wvalid  input  as downstream  master N W channel (mN_wlast monitored only)
mN_wready  output  1  master N W ready
mN_bid,mN_bresp,mN_bvalid  output  ID_W,2,1  master N B channel
mN_bready  input  1  master N B ready
mN_grnt  output  1  master N owns the write port
wlast_err  output  1  one-cycle pulse: master wlast disagrees with counter

Behaviour:
- Reset (aresetn=0 at edge): state=IDLE, grants 0, last_grant=1 (so m0 wins first tie), beat counter 0, len 0, wlast_err 0. All downstream valids and bready 0; all master readys and bvalids 0; all payload outputs 0.
- States: IDLE, ADDR, DATA, RESP. Exactly one mN_grnt is 1 in ADDR/DATA/RESP; both 0 in IDLE.
- IDLE: if only one mN_awvalid=1, grant it; if both, grant the master that is not last_grant; latch grant, update last_grant, go ADDR next cycle. Nothing is forwarded in IDLE (1-cycle arbitration latency).
- ADDR: AW payload/awvalid from granted master; mN_awready=awready for granted, 0 for other. On awvalid&&awready: latch awlen to len, clear counter, go DATA.
- DATA: W payload/wvalid from granted master, wready to granted master only. wlast = (counter==len). Each wvalid&&wready: counter+1 (4-bit). On handshake with counter==len go RESP. If mN_wlast != wlast on a handshake beat, pulse wlast_err for one cycle; the burst still follows the counter.
- RESP: bready=granted mN_bready; granted master sees bid/bresp/bvalid. On bvalid&&bready go IDLE, clear grant.
- Non-granted master: all its outputs 0; downstream signals not owned by current state are 0 (e.g. awvalid=0 in DATA).
- awlen=0: single beat, wlast=1 on first beat. awlen=15: 16 beats, counter reaches 15 without wrap.
- W data offered before grant/DATA is stalled (wready=0); B accepted only in RESP.
- Request withdrawn by master in ADDR is not expected; the block holds ADDR until handshake.
- Reset mid-transaction: returns to IDLE immediately, all outputs to reset values; in-flight burst abandoned.

Test Plan:
- m0 single write, awlen=0, addr 0x1FC0_0000, wdata 0xDEADBEEF, awready/wready/bready immediate -> m0_grnt rises cycle after awvalid, one beat with wlast=1, B okay to m0, back to IDLE; m1 outputs stay 0.
- Both masters request in same cycle from reset -> m0 served first, m1 granted on the IDLE cycle after m0's B handshake; repeat -> alternating m0,m1.
- m1 burst awlen=3 with wready toggled 1,0,1,0... -> exactly 4 transfers, wlast only on 4th, data order preserved, RESP entered after 4th handshake.
- m0 awlen=15, master wlast asserted on beat 8 -> wlast_err pulses once, downstream wlast only on beat 16.
- bvalid held 3 cycles with m0_bready=0, then 1 -> stays RESP; IDLE one cycle after bready handshake; bid/bresp=2'b10 passed unchanged.
- aresetn=0 during DATA beat 2 of 4 -> next cycle all valids/readys/grants 0, state IDLE; new m1 request then served normally.
